pc_sequencer: RTL and testbench

Sequential program-counter controller for the pipelined core. It owns the PC register and resolves control flow from the ID stage: sequential fetch, jump, taken branch (BEQ/BNE), CALL and RET. It keeps a small return-address stack (RAS) and issues the IF/ID flush on every redirect. It sits between the instruction-memory address port and the ID-stage decode/compare logic. After each redirect it masks the wrong-path slot through a two-state FSM.

---
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter controller: sequential fetch, jump, branch, CALL/RET via a circular
// return-address stack, IF/ID flush on redirect and a one-cycle wrong-path shadow.
module pc_sequencer #(
  parameter int unsigned     PC_W      = 16,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            id_valid,
  input  logic [3:0]      id_op,
  input  logic [2:0]      id_func,
  input  logic            id_zero,
  input  logic [PC_W-1:0] id_pc_plus1,
  input  logic [PC_W-1:0] jump_target,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      pc_src,
  output logic            flush_if,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  // Opcode map: 0..5 never redirect, 6/7 are the compare branches, 8..15 the jump class.
  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpAndi = 4'h1;
  localparam logic [3:0] OpAddi = 4'h2;
  localparam logic [3:0] OpLw   = 4'h3;
  localparam logic [3:0] OpSw   = 4'h4;
  localparam logic [3:0] OpFor  = 4'h5;
  localparam logic [3:0] OpBeq  = 4'h6;
  localparam logic [3:0] OpBne  = 4'h7;
  localparam logic [2:0] FnCall = 3'b001;
  localparam logic [2:0] FnRet  = 3'b010;

  localparam logic [1:0] SrcSeq  = 2'b00;
  localparam logic [1:0] SrcJump = 2'b01;
  localparam logic [1:0] SrcBr   = 2'b10;
  localparam logic [1:0] SrcRet  = 2'b11;

  typedef enum logic [0:0] {StRun, StShadow} state_e;

  state_e          r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic [PC_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_top, w_top_inc;
  logic [CNT_W-1:0] r_count;
  logic            r_ovf, r_unf;
  logic            w_active, w_push, w_pop, w_unf, w_full;
  logic [1:0]      w_src;

  assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
  assign w_top_inc = r_top + PTR_W'(1);
  assign w_active  = id_valid && (r_state == StRun) && !stall;

  always_comb begin
    w_src  = SrcSeq;
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_unf  = 1'b0;
    if (w_active) begin
      case (id_op)
        OpNop, OpAndi, OpAddi, OpLw, OpSw, OpFor: w_src = SrcSeq;
        OpBeq: w_src = id_zero ? SrcBr : SrcSeq;
        OpBne: w_src = id_zero ? SrcSeq : SrcBr;
        default: begin
          if (id_func == FnRet) begin
            // RET on an empty stack falls through as a plain sequential fetch.
            if (r_count == '0) begin
              w_unf = 1'b1;
            end else begin
              w_src = SrcRet;
              w_pop = 1'b1;
            end
          end else begin
            w_src  = SrcJump;
            w_push = (id_func == FnCall);
          end
        end
      endcase
    end
  end

  always_comb begin
    w_pc_next = r_pc + PC_W'(1);
    unique case (w_src)
      SrcSeq:  w_pc_next = r_pc + PC_W'(1);
      SrcJump: w_pc_next = jump_target;
      SrcBr:   w_pc_next = branch_target;
      SrcRet:  w_pc_next = r_ras[r_top];
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (!stall) begin
      unique case (r_state)
        StRun:    w_state_next = (w_src != SrcSeq) ? StShadow : StRun;
        StShadow: w_state_next = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
      r_pc    <= RESET_PC;
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!stall) begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_push) begin
        r_top <= w_top_inc;
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end else if (w_pop) begin
        r_top   <= r_top - PTR_W'(1);
        r_count <= r_count - CNT_W'(1);
      end
      if (w_unf) begin
        r_unf <= 1'b1;
      end
    end
  end

  // Entries carry no reset; the count alone decides which are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[w_top_inc] <= id_pc_plus1;
    end
  end

  assign pc            = r_pc;
  assign pc_src        = w_src;
  assign flush_if      = (w_src != SrcSeq);
  assign ras_empty     = (r_count == '0);
  assign ras_full      = w_full;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue-based control-flow model checked every cycle,
// plus literal expectations pinned by the stimulus.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        id_valid = 1'b0;
  logic [3:0]  id_op = 4'h0;
  logic [2:0]  id_func = 3'h0;
  logic        id_zero = 1'b0;
  logic [15:0] id_pc_plus1 = 16'h0;
  logic [15:0] jump_target = 16'h0;
  logic [15:0] branch_target = 16'h0;
  logic [15:0] pc;
  logic [1:0]  pc_src;
  logic        flush_if, ras_empty, ras_full, ras_overflow, ras_underflow;

  pc_sequencer #(
    .PC_W(16),
    .RAS_DEPTH(4),
    .RESET_PC(16'h0010)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .id_valid(id_valid),
    .id_op(id_op),
    .id_func(id_func),
    .id_zero(id_zero),
    .id_pc_plus1(id_pc_plus1),
    .jump_target(jump_target),
    .branch_target(branch_target),
    .pc(pc),
    .pc_src(pc_src),
    .flush_if(flush_if),
    .ras_empty(ras_empty),
    .ras_full(ras_full),
    .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Literal expectations armed by the stimulus for the current cycle.
  logic        lit_pc_en = 1'b0, lit_src_en = 1'b0;
  logic [15:0] lit_pc = 16'h0;
  logic [1:0]  lit_src = 2'b00;
  string       lit_name = "";

  int rst_cnt = 0;
  always @(negedge rst_n) rst_cnt++;

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model state: after a compare it holds what the DUT must show after the next edge.
  logic [15:0] m_pc = 16'h0010;
  logic        m_sh = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  logic [15:0] m_ras[$];
  int          rst_seen = 0;

  always @(negedge clk) begin
    logic       act, e_call, e_unf;
    logic [1:0] e_src;
    if (!rst_n || rst_cnt != rst_seen) begin
      rst_seen = rst_cnt;
      m_pc  = 16'h0010;
      m_sh  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_ras.delete();
    end
    act    = rst_n && id_valid && !m_sh && !stall;
    e_src  = 2'b00;
    e_call = 1'b0;
    e_unf  = 1'b0;
    if (act) begin
      if (id_op inside {[4'd0:4'd5]}) e_src = 2'b00;
      else if (id_op == 4'd6) e_src = id_zero ? 2'b10 : 2'b00;
      else if (id_op == 4'd7) e_src = id_zero ? 2'b00 : 2'b10;
      else if (id_func == 3'b010) begin
        if (m_ras.size() == 0) e_unf = 1'b1;
        else e_src = 2'b11;
      end else begin
        e_src  = 2'b01;
        e_call = (id_func == 3'b001);
      end
    end
    check("pc", pc, m_pc);
    check("pc_src", pc_src, e_src);
    check("flush_if", flush_if, e_src != 2'b00);
    check("ras_empty", ras_empty, m_ras.size() == 0);
    check("ras_full", ras_full, m_ras.size() == 4);
    check("ras_overflow", ras_overflow, m_ovf);
    check("ras_underflow", ras_underflow, m_unf);
    if (lit_pc_en) check({lit_name, "_pc"}, pc, lit_pc);
    if (lit_src_en) check({lit_name, "_src"}, pc_src, lit_src);
    if (rst_n && !stall) begin
      case (e_src)
        2'b00: m_pc = m_pc + 16'd1;
        2'b01: m_pc = jump_target;
        2'b10: m_pc = branch_target;
        default: begin
          m_pc = m_ras[$];
          void'(m_ras.pop_back());
        end
      endcase
      m_sh = (e_src != 2'b00);
      if (e_call) begin
        m_ras.push_back(id_pc_plus1);
        if (m_ras.size() > 4) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
      if (e_unf) m_unf = 1'b1;
    end
  end

  task automatic cyc(input logic v, input logic [3:0] op, input logic [2:0] fn,
                     input logic z, input logic st, input logic [15:0] jt,
                     input logic [15:0] bt, input logic [15:0] pp1);
    id_valid = v; id_op = op; id_func = fn; id_zero = z; stall = st;
    jump_target = jt; branch_target = bt; id_pc_plus1 = pp1;
    @(posedge clk);
    #1;
    lit_pc_en  = 1'b0;
    lit_src_en = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 3'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic exp_pc(input string nm, input logic [15:0] v);
    lit_name = nm; lit_pc = v; lit_pc_en = 1'b1;
  endtask

  task automatic exp_src(input string nm, input logic [1:0] v);
    lit_name = nm; lit_src = v; lit_src_en = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_pc("reset", 16'h0010); idle();
    exp_pc("seq1", 16'h0011);  idle();
    exp_pc("seq2", 16'h0012);  idle();
    // Taken BEQ, then a J ignored in the shadow slot, then a not-taken BNE.
    exp_src("beq", 2'b10);     cyc(1, 4'd6, 3'd0, 1, 0, 16'h0, 16'h0040, 16'h0);
    exp_pc("beq_tgt", 16'h0040);
    cyc(1, 4'd8, 3'd0, 0, 0, 16'h0999, 16'h0, 16'h0);
    exp_pc("shadow", 16'h0041);
    exp_src("bne_nt", 2'b00);  cyc(1, 4'd7, 3'd0, 1, 0, 16'h0, 16'h0777, 16'h0);
    // CALL then RET.
    exp_src("call", 2'b01);    cyc(1, 4'd8, 3'd1, 0, 0, 16'h0100, 16'h0, 16'h0021);
    exp_pc("call_tgt", 16'h0100); idle();
    exp_src("ret", 2'b11);     cyc(1, 4'd8, 3'd2, 0, 0, 16'h0, 16'h0, 16'h0);
    exp_pc("ret_tgt", 16'h0021); idle();
    // Five CALLs into a four-deep stack, then drain it and underflow.
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 4'd8, 3'd1, 0, 0, 16'h0200 + 16'(i), 16'h0, 16'(i));
      idle();
    end
    for (int k = 0; k < 4; k++) begin
      exp_src("ras_ret", 2'b11); cyc(1, 4'd8, 3'd2, 0, 0, 16'h0, 16'h0, 16'h0);
      exp_pc("ras_pop", 16'(5 - k)); idle();
    end
    exp_src("ret_empty", 2'b00); cyc(1, 4'd8, 3'd2, 0, 0, 16'h0, 16'h0, 16'h0);
    // Stall over a taken BEQ.
    for (int s = 0; s < 3; s++) begin
      exp_src("stall", 2'b00); cyc(1, 4'd6, 3'd0, 1, 1, 16'h0, 16'h0080, 16'h0);
    end
    exp_src("unstall", 2'b10); cyc(1, 4'd6, 3'd0, 1, 0, 16'h0, 16'h0080, 16'h0);
    exp_pc("unstall_tgt", 16'h0080); idle();
    // Stall while in the shadow slot.
    cyc(1, 4'd8, 3'd0, 0, 0, 16'h0090, 16'h0, 16'h0);
    exp_src("sh_stall", 2'b00); cyc(1, 4'd8, 3'd0, 0, 1, 16'h0555, 16'h0, 16'h0);
    exp_pc("sh_hold", 16'h0090); cyc(1, 4'd8, 3'd0, 0, 0, 16'h0555, 16'h0, 16'h0);
    exp_pc("sh_done", 16'h0091); idle();
    // Wrap from all-ones.
    cyc(1, 4'd9, 3'd0, 0, 0, 16'hFFFE, 16'h0, 16'h0);
    exp_pc("wrap_a", 16'hFFFE); idle();
    exp_pc("wrap_b", 16'hFFFF); idle();
    exp_pc("wrap_c", 16'h0000); idle();
    // Reset pulse in the middle of a shadow cycle.
    cyc(1, 4'd8, 3'd0, 0, 0, 16'h0300, 16'h0, 16'h0);
    id_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exp_pc("rst_mid", 16'h0010); idle();
    exp_src("post_rst_run", 2'b01); cyc(1, 4'd8, 3'd0, 0, 0, 16'h0050, 16'h0, 16'h0);
    exp_pc("post_rst_tgt", 16'h0050); idle();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
